pixel_probe_reader: RTL and testbench

- Sits beside vga_adapter on the same pixel-write stream (x, y, colour, plot) that the drawing FSMs drive.
- Keeps a 160x120x3 shadow copy of the screen.
- Answers box probes: "does any non-background pixel lie inside the XDIM x YDIM box at (x,y)?"
- Snake and apple logic use it for collision, apple-eaten and wall detection without reading vga_adapter's internal memory.

---
 rtl/pixel_probe_reader.sv | 167 ++++++++++++++++
 tb/tb_pixel_probe_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_probe_reader.sv
// Shadow copy of the 160x120x3 screen fed by the vga pixel-write stream, answering
// "any non-background pixel inside this box?" probes one pixel per cycle (sync-read RAM).
module pixel_probe_reader #(
  parameter int         XSCREEN = 160,
  parameter int         YSCREEN = 120,
  parameter int         XDIM    = 10,
  parameter int         YDIM    = 10,
  parameter logic [2:0] BG      = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       wr_plot,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [2:0] wr_colour,
  input  logic       probe_req,
  input  logic [7:0] probe_x,
  input  logic [6:0] probe_y,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic       oob,
  output logic [2:0] hit_colour,
  output logic [7:0] hit_x,
  output logic [6:0] hit_y
);

  localparam int                XCW   = $clog2(XDIM);
  localparam int                YCW   = $clog2(YDIM);
  localparam int                DEPTH = XSCREEN * YSCREEN;
  localparam logic [8:0]        XS9   = 9'(XSCREEN);
  localparam logic [8:0]        YS9   = 9'(YSCREEN);
  localparam logic [XCW-1:0]    XLAST = XCW'(XDIM - 1);
  localparam logic [YCW-1:0]    YLAST = YCW'(YDIM - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] yy;
    yy = {8'b0, y};
    return (yy << 7) + (yy << 5) + {7'b0, x};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       px0_q, px0_d;
  logic [6:0]       py0_q, py0_d;
  logic [XCW-1:0]   xc_q, xc_d;
  logic [YCW-1:0]   yc_q, yc_d;
  logic             e_v_q, e_oob_q;
  logic [7:0]       e_x_q;
  logic [6:0]       e_y_q;
  logic             hit_q, hit_d, oob_q, oob_d;
  logic [2:0]       col_q, col_d;
  logic [7:0]       hx_q, hx_d;
  logic [6:0]       hy_q, hy_d;

  logic [2:0]       mem [DEPTH];
  logic [2:0]       rd_q;

  logic [8:0]       px, py;
  logic             pix_off, issue, rd_en, wr_ok, eval_hit;

  assign px       = {1'b0, px0_q} + 9'(xc_q);
  assign py       = {2'b0, py0_q} + 9'(yc_q);
  assign pix_off  = (px >= XS9) || (py >= YS9);
  assign issue    = (state_q == SCAN);
  assign rd_en    = issue && !pix_off;
  assign wr_ok    = wr_plot && ({1'b0, wr_x} < XS9) && ({2'b0, wr_y} < YS9);
  assign eval_hit = ((state_q == SCAN) || (state_q == DRAIN)) && e_v_q &&
                    (e_oob_q || (rd_q != BG));

  // Non-blocking write and read of the same address: the read sees the old colour.
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) mem[pix_addr(wr_x, wr_y)] <= wr_colour;
    if (rd_en) rd_q <= mem[pix_addr(px[7:0], py[6:0])];
  end

  always_comb begin
    state_d = state_q;
    px0_d   = px0_q;
    py0_d   = py0_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    hit_d   = hit_q;
    oob_d   = oob_q;
    col_d   = col_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    case (state_q)
      IDLE: if (probe_req) begin
        state_d = SCAN;
        px0_d   = probe_x;
        py0_d   = probe_y;
        xc_d    = '0;
        yc_d    = '0;
        hit_d   = 1'b0;
        oob_d   = 1'b0;
        col_d   = BG;
        hx_d    = '0;
        hy_d    = '0;
      end
      SCAN: begin
        if (xc_q == XLAST) begin
          xc_d = '0;
          yc_d = yc_q + 1'b1;
        end else begin
          xc_d = xc_q + 1'b1;
        end
        if (eval_hit)                               state_d = DONE;
        else if ((xc_q == XLAST) && (yc_q == YLAST)) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    // First hit wins; the read issued alongside it is simply never evaluated.
    if (eval_hit) begin
      hit_d = 1'b1;
      oob_d = e_oob_q;
      col_d = e_oob_q ? BG : rd_q;
      hx_d  = e_x_q;
      hy_d  = e_y_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      px0_q   <= '0;
      py0_q   <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      e_v_q   <= 1'b0;
      e_oob_q <= 1'b0;
      e_x_q   <= '0;
      e_y_q   <= '0;
      hit_q   <= 1'b0;
      oob_q   <= 1'b0;
      col_q   <= '0;
      hx_q    <= '0;
      hy_q    <= '0;
    end else begin
      state_q <= state_d;
      px0_q   <= px0_d;
      py0_q   <= py0_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      e_v_q   <= issue;
      e_oob_q <= pix_off;
      e_x_q   <= px[7:0];
      e_y_q   <= py[6:0];
      hit_q   <= hit_d;
      oob_q   <= oob_d;
      col_q   <= col_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign hit        = hit_q;
  assign oob        = oob_q;
  assign hit_colour = col_q;
  assign hit_x      = hx_q;
  assign hit_y      = hy_q;

endmodule

// File: tb/tb_pixel_probe_reader.sv
// Directed bench for pixel_probe_reader: latency, hit capture, off-screen, write drop,
// held requests, mid-probe reset and same-cycle write/read ordering.
module tb_pixel_probe_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_plot;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [2:0] wr_colour;
  logic       probe_req;
  logic [7:0] probe_x;
  logic [6:0] probe_y;
  logic       busy, done, hit, oob;
  logic [2:0] hit_colour;
  logic [7:0] hit_x;
  logic [6:0] hit_y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_probe_reader dut (
    .CLOCK_50  (clk),
    .Resetn    (rst_n),
    .wr_plot   (wr_plot),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_colour (wr_colour),
    .probe_req (probe_req),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .oob       (oob),
    .hit_colour(hit_colour),
    .hit_x     (hit_x),
    .hit_y     (hit_y)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    wr_plot = 1'b1; wr_x = x; wr_y = y; wr_colour = c;
    tick;
    wr_plot = 1'b0;
  endtask

  // Issues one probe; returns the done latency (-1 on timeout), leaves time in the done cycle.
  task automatic do_probe(input logic [7:0] x, input logic [6:0] y,
                          output int lat, output bit busy_ok);
    tick;
    busy_ok   = (busy === 1'b0);
    probe_req = 1'b1; probe_x = x; probe_y = y;
    tick;
    probe_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy, done, hit, oob, hit_colour, hit_x, hit_y} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, hit, oob, hit_colour, hit_x, hit_y});
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_empty;
    int lat; bit bok;
    do_probe(8'd0, 7'd0, lat, bok);
    checks++; if (lat != 102) begin failures++; $display("FAIL empty_lat got=%0d exp=102", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL empty_busy got=%0d exp=1", bok); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== 20'd0) begin
      failures++; $display("FAIL empty_result got=%h exp=0", {hit, oob, hit_colour, hit_x, hit_y});
    end
    tick;
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL empty_after got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_hit_mid;
    int lat; bit bok;
    wr_pix(8'd85, 7'd63, 3'b100);
    do_probe(8'd80, 7'd60, lat, bok);
    checks++; if (lat != 38) begin failures++; $display("FAIL mid_lat got=%0d exp=38", lat); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== {1'b1, 1'b0, 3'b100, 8'd85, 7'd63}) begin
      failures++; $display("FAIL mid_result got=%b/%b/%b/%0d/%0d exp=1/0/100/85/63", hit, oob, hit_colour, hit_x, hit_y);
    end
  endtask

  task automatic test_oob;
    int lat; bit bok;
    do_probe(8'd155, 7'd20, lat, bok);
    checks++; if (lat != 8) begin failures++; $display("FAIL oob_edge_lat got=%0d exp=8", lat); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== {1'b1, 1'b1, 3'b000, 8'd160, 7'd20}) begin
      failures++; $display("FAIL oob_edge_result got=%b/%b/%b/%0d/%0d exp=1/1/000/160/20", hit, oob, hit_colour, hit_x, hit_y);
    end
    do_probe(8'd250, 7'd115, lat, bok);
    checks++; if (lat != 3) begin failures++; $display("FAIL oob_far_lat got=%0d exp=3", lat); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== {1'b1, 1'b1, 3'b000, 8'd250, 7'd115}) begin
      failures++; $display("FAIL oob_far_result got=%b/%b/%b/%0d/%0d exp=1/1/000/250/115", hit, oob, hit_colour, hit_x, hit_y);
    end
  endtask

  task automatic test_corner;
    int lat; bit bok;
    wr_pix(8'd159, 7'd119, 3'b010);
    wr_pix(8'd160, 7'd0, 3'b111);
    do_probe(8'd150, 7'd110, lat, bok);
    checks++; if (lat != 102) begin failures++; $display("FAIL corner_lat got=%0d exp=102", lat); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== {1'b1, 1'b0, 3'b010, 8'd159, 7'd119}) begin
      failures++; $display("FAIL corner_result got=%b/%b/%b/%0d/%0d exp=1/0/010/159/119", hit, oob, hit_colour, hit_x, hit_y);
    end
    do_probe(8'd0, 7'd0, lat, bok);
    checks++; if (lat != 102) begin failures++; $display("FAIL drop_lat got=%0d exp=102", lat); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL drop_hit got=%b exp=0", hit); end
  endtask

  task automatic test_back_to_back;
    int k1, k2;
    tick;
    probe_req = 1'b1; probe_x = 8'd0; probe_y = 7'd0;
    tick;
    k1 = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done === 1'b1) begin k1 = k; break; end
      tick;
    end
    checks++; if (k1 != 102) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=102", k1); end
    tick;
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL b2b_gap got=%b exp=00", {busy, done}); end
    tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept got=%b exp=1", busy); end
    probe_req = 1'b0;
    k2 = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done === 1'b1) begin k2 = k; break; end
      tick;
    end
    checks++; if (k2 != 102) begin failures++; $display("FAIL b2b_second_lat got=%0d exp=102", k2); end
  endtask

  task automatic test_reset_mid;
    int lat; bit bok; bit saw_done;
    tick;
    probe_req = 1'b1; probe_x = 8'd150; probe_y = 7'd110;
    tick;
    probe_req = 1'b0;
    repeat (19) tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hit, oob, hit_colour, hit_x, hit_y} !== 23'd0) begin
      failures++; $display("FAIL rstmid_outputs got=%h exp=0", {busy, done, hit, oob, hit_colour, hit_x, hit_y});
    end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", saw_done); end
    do_probe(8'd150, 7'd110, lat, bok);
    checks++; if (lat != 102) begin failures++; $display("FAIL rstmid_reprobe_lat got=%0d exp=102", lat); end
    checks++;
    if ({hit, hit_colour, hit_x, hit_y} !== {1'b1, 3'b010, 8'd159, 7'd119}) begin
      failures++; $display("FAIL rstmid_reprobe got=%b/%b/%0d/%0d exp=1/010/159/119", hit, hit_colour, hit_x, hit_y);
    end
  endtask

  task automatic test_same_cycle_write;
    int lat; bit bok;
    tick;
    probe_req = 1'b1; probe_x = 8'd40; probe_y = 7'd40;
    tick;
    // Pixel 0 of the box is issued in this cycle; the write lands on it simultaneously.
    probe_req = 1'b0;
    wr_plot = 1'b1; wr_x = 8'd40; wr_y = 7'd40; wr_colour = 3'b001;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      tick;
      wr_plot = 1'b0;
    end
    wr_plot = 1'b0;
    checks++; if (lat != 102) begin failures++; $display("FAIL rdw_lat got=%0d exp=102", lat); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rdw_hit got=%b exp=0", hit); end
    do_probe(8'd40, 7'd40, lat, bok);
    checks++; if (lat != 3) begin failures++; $display("FAIL rdw_reprobe_lat got=%0d exp=3", lat); end
    checks++;
    if ({hit, oob, hit_colour, hit_x, hit_y} !== {1'b1, 1'b0, 3'b001, 8'd40, 7'd40}) begin
      failures++; $display("FAIL rdw_reprobe got=%b/%b/%b/%0d/%0d exp=1/0/001/40/40", hit, oob, hit_colour, hit_x, hit_y);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    wr_plot   = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_colour = '0;
    probe_req = 1'b0;
    probe_x   = '0;
    probe_y   = '0;
    test_reset;
    test_empty;
    test_hit_mid;
    test_oob;
    test_corner;
    test_back_to_back;
    test_reset_mid;
    test_same_cycle_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
